// File: rtl/axi4dma_dscrptr_mem_if.sv
// Descriptor memory port: 4-beat AXI4 read to fetch a 128-bit descriptor, single-byte AXI4 write for status.
// Latency: AR/AW issued the cycle after a request is accepted; done pulses one cycle after the last R/B handshake.
module axi4dma_dscrptr_mem_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DSCRPTR_ID = 0
) (
  input  logic                CLOCK,
  input  logic                RESETn,
  input  logic                fetchReq,
  input  logic                statReq,
  input  logic [31:0]         reqAddr,
  input  logic [7:0]          statData,
  output logic                busy,
  output logic                fetchDone,
  output logic                statDone,
  output logic [127:0]        dscrptrData,
  output logic [1:0]          rspCode,
  output logic                rspErr,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [31:0]         ARADDR,
  output logic [ID_WIDTH-1:0] ARID,
  output logic [7:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [31:0]         RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic [ID_WIDTH-1:0] RID,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [31:0]         AWADDR,
  output logic [ID_WIDTH-1:0] AWID,
  output logic [7:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [31:0]         WDATA,
  output logic [3:0]          WSTRB,
  output logic                WLAST,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  input  logic [ID_WIDTH-1:0] BID
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] beat;
  logic       aw_ok, w_ok, r_hs;
  logic       unused_ids;

  assign ARID    = ID_WIDTH'(DSCRPTR_ID);
  assign AWID    = ID_WIDTH'(DSCRPTR_ID);
  assign ARLEN   = 8'd3;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign AWLEN   = 8'd0;
  assign AWSIZE  = 3'b000;
  assign AWBURST = 2'b01;
  assign WLAST   = 1'b1;

  assign unused_ids = ^{RID, BID};

  // AW and W complete independently; a channel already dropped counts as done.
  assign aw_ok = !AWVALID || AWREADY;
  assign w_ok  = !WVALID || WREADY;
  assign r_hs  = RVALID && RREADY;

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fetchReq)     state_nxt = RD_ADDR;
        else if (statReq) state_nxt = WR_REQ;
      end
      RD_ADDR: if (ARVALID && ARREADY)     state_nxt = RD_DATA;
      RD_DATA: if (r_hs && beat == 2'd3)   state_nxt = DONE;
      WR_REQ:  if (aw_ok && w_ok)          state_nxt = WR_RESP;
      WR_RESP: if (BVALID && BREADY)       state_nxt = DONE;
      DONE:                                state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      busy        <= 1'b0;
      fetchDone   <= 1'b0;
      statDone    <= 1'b0;
      dscrptrData <= '0;
      rspCode     <= 2'b00;
      rspErr      <= 1'b0;
      beat        <= 2'd0;
      ARVALID     <= 1'b0;
      ARADDR      <= '0;
      RREADY      <= 1'b0;
      AWVALID     <= 1'b0;
      AWADDR      <= '0;
      WVALID      <= 1'b0;
      WDATA       <= '0;
      WSTRB       <= '0;
      BREADY      <= 1'b0;
    end else begin
      fetchDone <= 1'b0;
      statDone  <= 1'b0;
      busy      <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (fetchReq) begin
            ARVALID <= 1'b1;
            ARADDR  <= {reqAddr[31:4], 4'b0};
            beat    <= 2'd0;
            rspCode <= 2'b00;
            rspErr  <= 1'b0;
          end else if (statReq) begin
            AWVALID <= 1'b1;
            WVALID  <= 1'b1;
            AWADDR  <= reqAddr;
            WDATA   <= {4{statData}};
            WSTRB   <= 4'b0001 << reqAddr[1:0];
            rspCode <= 2'b00;
            rspErr  <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            dscrptrData[{beat, 5'd0} +: 32] <= RDATA;
            beat <= beat + 2'd1;
            if (RRESP > rspCode) rspCode <= RRESP;
            // Framing error: RLAST must coincide exactly with the fourth beat.
            rspErr <= rspErr | RRESP[1] | (RLAST != (beat == 2'd3));
            if (beat == 2'd3) begin
              RREADY    <= 1'b0;
              fetchDone <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (AWREADY) AWVALID <= 1'b0;
          if (WREADY)  WVALID  <= 1'b0;
          if (aw_ok && w_ok) BREADY <= 1'b1;
        end
        WR_RESP: begin
          if (BVALID) begin
            BREADY   <= 1'b0;
            rspCode  <= BRESP;
            rspErr   <= BRESP[1];
            statDone <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4dma_dscrptr_mem_if.sv
// Directed bench for the descriptor memory port: fetch, status write, collisions, error responses, reset abort.
module tb_axi4dma_dscrptr_mem_if;

  logic         CLOCK = 1'b0;
  logic         RESETn;
  logic         fetchReq, statReq;
  logic [31:0]  reqAddr;
  logic [7:0]   statData;
  logic         busy, fetchDone, statDone, rspErr;
  logic [127:0] dscrptrData;
  logic [1:0]   rspCode;
  logic         ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [31:0]  ARADDR, RDATA;
  logic [3:0]   ARID, RID, AWID, BID;
  logic [7:0]   ARLEN, AWLEN;
  logic [2:0]   ARSIZE, AWSIZE;
  logic [1:0]   ARBURST, AWBURST, RRESP, BRESP;
  logic         AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [31:0]  AWADDR, WDATA;
  logic [3:0]   WSTRB;

  int checks = 0;
  int errors = 0;
  int ar_hs = 0, r_hs = 0, aw_cyc = 0, fd_cnt = 0, sd_cnt = 0;
  int s_ar, s_r, s_aw, s_fd, s_sd;

  logic [31:0] bdat [4];
  logic [1:0]  bresp [4];
  logic        blast [4];

  always #5 CLOCK = ~CLOCK;

  axi4dma_dscrptr_mem_if #(.ID_WIDTH(4), .DSCRPTR_ID(0)) dut (
    .CLOCK(CLOCK), .RESETn(RESETn),
    .fetchReq(fetchReq), .statReq(statReq), .reqAddr(reqAddr), .statData(statData),
    .busy(busy), .fetchDone(fetchDone), .statDone(statDone), .dscrptrData(dscrptrData),
    .rspCode(rspCode), .rspErr(rspErr),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RID(RID),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID)
  );

  always @(posedge CLOCK) begin
    if (ARVALID && ARREADY) ar_hs++;
    if (RVALID && RREADY)   r_hs++;
    if (AWVALID)            aw_cyc++;
    if (fetchDone)          fd_cnt++;
    if (statDone)           sd_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_ar = ar_hs; s_r = r_hs; s_aw = aw_cyc; s_fd = fd_cnt; s_sd = sd_cnt;
  endtask

  task automatic set_beats(input logic [31:0] base, input logic [7:0] resp, input logic [3:0] last);
    for (int i = 0; i < 4; i++) begin
      bdat[i]  = base + 32'(i);
      bresp[i] = resp[2*i +: 2];
      blast[i] = last[i];
    end
  endtask

  task automatic start_fetch(input logic [31:0] a, input logic with_stat);
    @(negedge CLOCK);
    fetchReq = 1'b1; statReq = with_stat; reqAddr = a; statData = 8'h5A;
    @(negedge CLOCK);
    fetchReq = 1'b0; statReq = 1'b0;
  endtask

  task automatic do_read(input int n);
    int k;
    int t;
    k = 0; t = 0;
    while (k < n && t < 40) begin
      @(negedge CLOCK);
      RVALID = 1'b1; RDATA = bdat[k]; RRESP = bresp[k]; RLAST = blast[k];
      if (RREADY) k++;
      t++;
    end
    if (k < n) chk("rd_timeout", 128'(k), 128'(n));
  endtask

  task automatic end_read();
    @(negedge CLOCK);
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
  endtask

  initial begin
    RESETn = 1'b0; fetchReq = 0; statReq = 0; reqAddr = 0; statData = 0;
    ARREADY = 1'b1; RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RID = 4'h3;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 4'h5;
    repeat (3) @(negedge CLOCK);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 0);
    chk("rst_done", {fetchDone, statDone}, 0);
    chk("rst_data", dscrptrData, 0);
    chk("rst_rsp", {rspCode, rspErr}, 0);
    RESETn = 1'b1;

    // Basic fetch, unaligned address.
    snap();
    set_beats(32'h11, 8'h00, 4'b1000);
    bdat[1] = 32'h22; bdat[2] = 32'h33; bdat[3] = 32'h44;
    start_fetch(32'h1000_0014, 1'b0);
    chk("f1_arvalid", ARVALID, 1);
    chk("f1_araddr", ARADDR, 32'h1000_0010);
    chk("f1_arctl", {ARLEN, ARSIZE, ARBURST, ARID}, {8'd3, 3'b010, 2'b01, 4'd0});
    chk("f1_busy", busy, 1);
    do_read(4);
    end_read();
    chk("f1_done", fetchDone, 1);
    chk("f1_data", dscrptrData, 128'h00000044_00000033_00000022_00000011);
    chk("f1_rsp", {rspCode, rspErr}, 3'b000);
    @(negedge CLOCK);
    chk("f1_done_low", {fetchDone, busy}, 0);
    chk("f1_cnt", {8'(fd_cnt - s_fd), 8'(r_hs - s_r), 8'(ar_hs - s_ar)}, {8'd1, 8'd4, 8'd1});

    // Status write, W accepted three cycles before AW.
    snap();
    AWREADY = 1'b0; WREADY = 1'b0;
    @(negedge CLOCK);
    statReq = 1'b1; reqAddr = 32'h2000_0007; statData = 8'hA5;
    @(negedge CLOCK);
    statReq = 1'b0;
    chk("w1_valids", {AWVALID, WVALID}, 2'b11);
    chk("w1_awaddr", AWADDR, 32'h2000_0007);
    chk("w1_wdata", WDATA, 32'hA5A5_A5A5);
    chk("w1_wstrb", WSTRB, 4'b1000);
    chk("w1_awctl", {AWLEN, AWSIZE, AWBURST, WLAST, AWID}, {8'd0, 3'b000, 2'b01, 1'b1, 4'd0});
    WREADY = 1'b1;
    @(negedge CLOCK);
    WREADY = 1'b0;
    chk("w1_w_drop", {AWVALID, WVALID}, 2'b10);
    repeat (2) @(negedge CLOCK);
    AWREADY = 1'b1;
    @(negedge CLOCK);
    AWREADY = 1'b0;
    chk("w1_bready", {AWVALID, BREADY}, 2'b01);
    BVALID = 1'b1; BRESP = 2'b00;
    @(negedge CLOCK);
    BVALID = 1'b0;
    chk("w1_done", {statDone, fetchDone}, 2'b10);
    chk("w1_rsp", {rspCode, rspErr}, 3'b000);
    chk("w1_keep_data", dscrptrData, 128'h00000044_00000033_00000022_00000011);
    @(negedge CLOCK);
    chk("w1_done_low", {statDone, busy}, 0);
    chk("w1_cnt", 8'(sd_cnt - s_sd), 1);

    // Fetch and status request together: fetch wins, no write traffic.
    snap();
    set_beats(32'hB0, 8'h00, 4'b1000);
    start_fetch(32'h0000_0100, 1'b1);
    do_read(4);
    end_read();
    @(negedge CLOCK);
    chk("c_data", dscrptrData, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    chk("c_cnt", {8'(fd_cnt - s_fd), 8'(sd_cnt - s_sd), 8'(aw_cyc - s_aw), 8'(ar_hs - s_ar)},
        {8'd1, 8'd0, 8'd0, 8'd1});

    // SLVERR on beat 1, early RLAST on beat 2.
    snap();
    set_beats(32'hC0, 8'b00_00_10_00, 4'b0100);
    start_fetch(32'h0000_0200, 1'b0);
    do_read(4);
    end_read();
    @(negedge CLOCK);
    chk("e_rsp", {rspCode, rspErr}, 3'b101);
    chk("e_data", dscrptrData, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    chk("e_cnt", {8'(fd_cnt - s_fd), 8'(r_hs - s_r)}, {8'd1, 8'd4});

    // Missing RLAST with EXOKAY responses: framing error only.
    set_beats(32'hD0, 8'b01_00_01_00, 4'b0000);
    start_fetch(32'h0000_0300, 1'b0);
    do_read(4);
    end_read();
    @(negedge CLOCK);
    chk("nl_rsp", {rspCode, rspErr}, 3'b011);

    // Write with DECERR and both channels ready together.
    snap();
    AWREADY = 1'b1; WREADY = 1'b1;
    @(negedge CLOCK);
    statReq = 1'b1; reqAddr = 32'h4000_0001; statData = 8'h3C;
    @(negedge CLOCK);
    statReq = 1'b0;
    chk("w2_wstrb", {WSTRB, WDATA}, {4'b0010, 32'h3C3C_3C3C});
    @(negedge CLOCK);
    AWREADY = 1'b0; WREADY = 1'b0;
    BVALID = 1'b1; BRESP = 2'b11;
    @(negedge CLOCK);
    BVALID = 1'b0; BRESP = 2'b00;
    chk("w2_rsp", {statDone, rspCode, rspErr}, 4'b1111);
    chk("w2_keep_data", dscrptrData, {32'hD3, 32'hD2, 32'hD1, 32'hD0});

    // Reset in the middle of a burst.
    snap();
    set_beats(32'hE0, 8'h00, 4'b1000);
    start_fetch(32'h3000_0000, 1'b0);
    do_read(2);
    @(negedge CLOCK);
    RVALID = 1'b0;
    RESETn = 1'b0;
    #1;
    chk("r_busy", {busy, RREADY}, 0);
    chk("r_data", dscrptrData, 0);
    @(negedge CLOCK);
    RESETn = 1'b1;
    repeat (3) @(negedge CLOCK);
    chk("r_no_done", {8'(fd_cnt - s_fd), 7'(0), busy}, 0);
    set_beats(32'hF0, 8'h00, 4'b1000);
    start_fetch(32'h3000_0000, 1'b0);
    do_read(4);
    end_read();
    chk("r2_done", fetchDone, 1);
    chk("r2_data", dscrptrData, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    @(negedge CLOCK);
    chk("r2_cnt", 8'(fd_cnt - s_fd), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
